// File: rtl/bht_update_fifo.sv
// Resolved-branch update buffer feeding the bimodal predictor update port.
// Producer never stalls: outcomes arriving while full are dropped and counted.
`ifndef BHT_IDX_WIDTH
`define BHT_IDX_WIDTH 6
`endif

package bht_pkg;
  typedef enum logic [1:0] {
    PRIV = 2'd0,
    USER = 2'd1,
    INIT = 2'd2
  } domain_t;
endpackage

module bht_update_fifo
  import bht_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = `BHT_IDX_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     res_valid_i,
  input  logic [31:0]              res_pc_i,
  input  logic                     res_taken_i,
  input  logic [31:0]              res_targ_i,
  input  domain_t                  res_domain_i,
  input  logic                     flush_i,
  output logic                     deq_valid_o,
  input  logic                     deq_ready_i,
  output logic [IDX_W-1:0]         deq_idx_o,
  output logic                     deq_taken_o,
  output logic [31:0]              deq_targ_o,
  output domain_t                  deq_domain_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [CNT_W-1:0]         drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
    logic [31:0]      targ;
    domain_t          domain;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CNT_W-1:0] drop_cnt_reg;

  logic   deq_fire;
  logic   res_ok;
  logic   enq_ok;
  logic   drop;
  logic   is_full;
  entry_t head;
  entry_t new_entry;

  // Only the index bits of the PC are stored; the rest are intentionally ignored.
  logic unused_pc_parity;
  assign unused_pc_parity = ^res_pc_i;

  assign is_full   = (count_reg == CW'(DEPTH));
  assign deq_fire  = (count_reg != '0) && deq_ready_i;
  assign res_ok    = res_valid_i && (res_domain_i != INIT) && !flush_i;
  assign enq_ok    = res_ok && (!is_full || deq_fire);
  assign drop      = res_ok && is_full && !deq_fire;

  assign new_entry.idx    = res_pc_i[IDX_W+1:2];
  assign new_entry.taken  = res_taken_i;
  assign new_entry.targ   = res_targ_i;
  assign new_entry.domain = res_domain_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (drop && (drop_cnt_reg != '1)) begin
        drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
      if (flush_i) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (enq_ok) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        if (deq_fire) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
        if (enq_ok && !deq_fire) begin
          count_reg <= count_reg + 1'b1;
        end else if (!enq_ok && deq_fire) begin
          count_reg <= count_reg - 1'b1;
        end
      end
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (!rst_i && enq_ok) begin
      mem[wr_ptr_reg] <= new_entry;
    end
  end

  assign head = mem[rd_ptr_reg];

  assign deq_valid_o  = (count_reg != '0);
  assign deq_idx_o    = deq_valid_o ? head.idx   : '0;
  assign deq_taken_o  = deq_valid_o ? head.taken : 1'b0;
  assign deq_targ_o   = deq_valid_o ? head.targ  : 32'd0;
  assign deq_domain_o = deq_valid_o ? head.domain : INIT;
  assign full_o       = is_full;
  assign count_o      = count_reg;
  assign drop_cnt_o   = drop_cnt_reg;

endmodule
